// File: rtl/pc_seq.sv
// Fetch-stage program counter: increment, relative branch, absolute jump, call/return stack, stall and halt/resume.
// Optional return stack built only when PC_RETSTACK_EN is defined; otherwise call behaves as a jump and ret as an increment.
module pc_seq #(
   parameter int             D         = 10,
   parameter int             OW        = 8,
   parameter int             DEPTH     = 4,
   parameter logic [D-1:0]   RESET_VEC = '0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      stall,
   input  logic                      absjump_en,
   input  logic                      reljump_en,
   input  logic                      call_en,
   input  logic                      ret_en,
   input  logic                      halt_req,
   input  logic                      resume,
   input  logic [D-1:0]              target,
   input  logic [OW-1:0]             offset,
   output logic [D-1:0]              prog_ctr,
   output logic                      halted,
   output logic [$clog2(DEPTH):0]    stk_depth,
   output logic                      stk_ovf,
   output logic                      stk_unf
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = AW + 1;

   typedef enum logic {RUN, HALT} state_t;

   state_t         state;
   state_t         state_nxt;
   logic           active;
   logic [D-1:0]   pc_inc;
   logic [D-1:0]   off_ext;
   logic [D-1:0]   pc_nxt;

   assign active  = (state == RUN) && !stall;
   assign pc_inc  = prog_ctr + D'(1);
   assign off_ext = D'($signed(offset));

   always_ff @(posedge clk) begin
      if (!reset_n) state <= RUN;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:     if (halt_req && !stall) state_nxt = HALT;
         HALT:    if (resume)             state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   always_comb begin
      halted = (state == HALT);
   end

`ifdef PC_RETSTACK_EN
   logic [D-1:0]  stack [DEPTH];
   logic [DW-1:0] depth;
   logic          ovf;
   logic          unf;
   logic          push;
   logic          pop;
   logic          set_ovf;
   logic          set_unf;
   logic          stk_empty;
   logic          stk_full;
   logic [AW-1:0] top_idx;
   logic [AW-1:0] push_idx;

   assign stk_empty = (depth == '0);
   assign stk_full  = (depth == DW'(DEPTH));
   assign top_idx   = AW'(depth - DW'(1));
   assign push_idx  = AW'(depth);

   always_comb begin
      pc_nxt  = pc_inc;
      push    = 1'b0;
      pop     = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (ret_en) begin
         if (!stk_empty) begin
            pc_nxt = stack[top_idx];
            pop    = 1'b1;
         end else begin
            set_unf = 1'b1;
         end
      end else if (call_en) begin
         // The jump is taken even when the push has to be dropped.
         pc_nxt = target;
         if (!stk_full) push    = 1'b1;
         else           set_ovf = 1'b1;
      end else if (absjump_en) begin
         pc_nxt = target;
      end else if (reljump_en) begin
         pc_nxt = prog_ctr + off_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         depth <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else if (active) begin
         if (push)     depth <= depth + DW'(1);
         else if (pop) depth <= depth - DW'(1);
         ovf <= ovf | set_ovf;
         unf <= unf | set_unf;
      end
   end

   // Contents need no reset; only entries below depth are ever read.
   always_ff @(posedge clk) begin
      if (reset_n && active && push) stack[push_idx] <= pc_inc;
   end

   assign stk_depth = depth;
   assign stk_ovf   = ovf;
   assign stk_unf   = unf;
`else
   always_comb begin
      pc_nxt = pc_inc;
      if (ret_en)                      pc_nxt = pc_inc;
      else if (call_en || absjump_en)  pc_nxt = target;
      else if (reljump_en)             pc_nxt = prog_ctr + off_ext;
   end

   assign stk_depth = '0;
   assign stk_ovf   = 1'b0;
   assign stk_unf   = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n)    prog_ctr <= RESET_VEC;
      else if (active) prog_ctr <= pc_nxt;
   end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: a reference model predicts each cycle's outputs into a scoreboard queue.
module tb_pc_seq;

`ifdef PC_RETSTACK_EN
   localparam bit STK_EN = 1'b1;
`else
   localparam bit STK_EN = 1'b0;
`endif
   localparam logic [9:0] RV = 10'h010;

   logic       clk;
   logic       reset_n;
   logic       stall, absjump_en, reljump_en, call_en, ret_en, halt_req, resume;
   logic [9:0] target;
   logic [7:0] offset;
   logic [9:0] prog_ctr;
   logic       halted;
   logic [2:0] stk_depth;
   logic       stk_ovf, stk_unf;

   pc_seq #(.D(10), .OW(8), .DEPTH(4), .RESET_VEC(RV)) dut (
      .clk(clk), .reset_n(reset_n), .stall(stall), .absjump_en(absjump_en),
      .reljump_en(reljump_en), .call_en(call_en), .ret_en(ret_en),
      .halt_req(halt_req), .resume(resume), .target(target), .offset(offset),
      .prog_ctr(prog_ctr), .halted(halted), .stk_depth(stk_depth),
      .stk_ovf(stk_ovf), .stk_unf(stk_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [9:0] pc;
      logic       hlt;
      logic [2:0] dep;
      logic       ovf;
      logic       unf;
   } exp_t;

   exp_t       exp_q[$];
   logic [9:0] m_stk[$];
   logic [9:0] m_pc;
   logic       m_halt, m_ovf, m_unf;
   int         total  = 0;
   int         passed = 0;

   task automatic model_step();
      if (!reset_n) begin
         m_pc = RV; m_halt = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
         m_stk.delete();
      end else if (m_halt) begin
         if (resume) m_halt = 1'b0;
      end else if (!stall) begin
         if (ret_en) begin
            if (STK_EN && m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
               if (STK_EN) m_unf = 1'b1;
               m_pc = m_pc + 10'd1;
            end
         end else if (call_en) begin
            if (STK_EN) begin
               if (m_stk.size() < 4) m_stk.push_back(m_pc + 10'd1);
               else                  m_ovf = 1'b1;
            end
            m_pc = target;
         end else if (absjump_en) m_pc = target;
         else if (reljump_en)     m_pc = m_pc + {{2{offset[7]}}, offset};
         else                     m_pc = m_pc + 10'd1;
         if (halt_req) m_halt = 1'b1;
      end
   endtask

   task automatic check_bit(string tag, string fld, logic obs, logic exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s.%s observed=%0b expected=%0b", tag, fld, obs, exp);
   endtask

   task automatic check_vec(string tag, string fld, logic [9:0] obs, logic [9:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s.%s observed=0x%03h expected=0x%03h", tag, fld, obs, exp);
   endtask

   // Drive one cycle's controls, predict the result, then compare after the edge.
   task automatic step(string tag, bit st, bit ab, bit rl, bit cl, bit rt, bit hr, bit rs,
                       logic [9:0] tg = 10'h000, logic [7:0] of = 8'h00);
      exp_t e;
      stall = st; absjump_en = ab; reljump_en = rl; call_en = cl; ret_en = rt;
      halt_req = hr; resume = rs; target = tg; offset = of;
      model_step();
      e.tag = tag; e.pc = m_pc; e.hlt = m_halt; e.dep = 3'(m_stk.size());
      e.ovf = m_ovf; e.unf = m_unf;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check_vec(e.tag, "pc", prog_ctr, e.pc);
      check_bit(e.tag, "halted", halted, e.hlt);
      check_vec(e.tag, "depth", {7'd0, stk_depth}, {7'd0, e.dep});
      check_bit(e.tag, "ovf", stk_ovf, e.ovf);
      check_bit(e.tag, "unf", stk_unf, e.unf);
   endtask

   initial begin
      reset_n = 1'b0;
      step("rst0", 0,0,0,0,0,0,0);
      step("rst1", 0,0,0,0,0,0,0);
      reset_n = 1'b1;
      step("inc0", 0,0,0,0,0,0,0);
      step("inc1", 0,0,0,0,0,0,0);

      step("jmp3fe", 0,1,0,0,0,0,0, 10'h3FE);
      step("inc3ff", 0,0,0,0,0,0,0);
      step("wrap0",  0,0,0,0,0,0,0);
      step("jmp005", 0,1,0,0,0,0,0, 10'h005);
      step("relneg", 0,0,1,0,0,0,0, 10'h000, 8'hFA);
      step("jmp100", 0,1,0,0,0,0,0, 10'h100);
      step("relpos", 0,0,1,0,0,0,0, 10'h000, 8'h7F);

      step("jmp020", 0,1,0,0,0,0,0, 10'h020);
      step("call1",  0,0,0,1,0,0,0, 10'h200);
      step("call2",  0,0,0,1,0,0,0, 10'h300);
      step("ret1",   0,0,0,0,1,0,0);
      step("ret2",   0,0,0,0,1,0,0);

      for (int i = 0; i < 5; i++) step($sformatf("ovf_call%0d", i), 0,0,0,1,0,0,0, 10'h040 + 10'(i * 16));
      for (int i = 0; i < 5; i++) step($sformatf("unf_ret%0d", i),  0,0,0,0,1,0,0);
      step("sticky", 0,0,0,0,0,0,0);

      step("pcall",  0,0,0,1,0,0,0, 10'h123);
      step("prio",   0,1,0,1,1,0,0, 10'h155);
      step("pcall2", 0,0,0,1,0,0,0, 10'h180);
      step("stall",  1,0,0,1,0,0,0, 10'h2AA);
      step("stallh", 1,0,0,0,0,1,0);

      step("haltjmp", 0,1,0,0,0,1,0, 10'h0AA);
      step("hold_inc",  0,0,0,0,0,0,0);
      step("hold_jmp",  0,1,0,0,0,0,0, 10'h3C3);
      step("hold_call", 0,0,1,1,1,1,0, 10'h111, 8'h05);
      step("resume",    0,0,0,0,0,0,1);
      step("post_res",  0,0,0,0,0,0,0);

      step("halt2",  0,0,0,0,0,1,0);
      reset_n = 1'b0;
      step("rst_h",  0,0,0,0,0,0,0);
      reset_n = 1'b1;
      step("after_rst", 0,0,0,0,0,0,0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/pc_seq.md
Name: pc_seq

Overview:
- Next-generation program counter for the decoder core's fetch stage.
- Drives the instruction-memory address every cycle.
- Generalises the basic PC with:
  - parametrised width and reset vector
  - signed relative branch
  - absolute jump
  - call/return stack
  - stall and halt/resume control
  - sticky stack-error flags

Parameters:
D, 10, program-counter / address width in bits
OW, 8, width of signed relative branch offset (two's complement), OW <= D
DEPTH, 4, return-stack entries (power of 2, >= 2)
RESET_VEC, 0, value loaded into prog_ctr on reset

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  synchronous reset, active-low
stall  input  1  hold PC and all state this cycle
absjump_en  input  1  absolute jump to target
reljump_en  input  1  relative branch by offset
call_en  input  1  push return address, jump to target
ret_en  input  1  pop return address into PC
halt_req  input  1  enter HALT after this cycle
resume  input  1  leave HALT
target  input  D  absolute jump / call destination
offset  input  OW  signed relative branch displacement
prog_ctr  output  D  current program counter (registered)
halted  output  1  high while in HALT state
stk_depth  output  clog2(DEPTH)+1  current number of stack entries
stk_ovf  output  1  sticky: push attempted on full stack
stk_unf  output  1  sticky: pop attempted on empty stack

Behaviour:
- Reset (reset_n low at a rising edge, sampled synchronously):
  - prog_ctr=RESET_VEC, state=RUN, halted=0.
  - stk_depth=0, stk_ovf=0, stk_unf=0.
  - Stack contents are don't-care.
  - Reset overrides everything, including mid-halt and mid-stall.
- FSM states: RUN, HALT.
  - RUN -> HALT when halt_req=1 and stall=0. The PC update for that cycle still happens.
  - HALT -> RUN when resume=1. The PC is unchanged on the resume edge; updates resume on the following cycle.
  - In HALT all control inputs except resume and reset_n are ignored; prog_ctr and the stack hold. halted=1.
- In RUN, the update priority per cycle (highest first) is stall > ret_en > call_en > absjump_en > reljump_en > increment:
  - stall: prog_ctr, stack and flags hold.
  - ret_en, stack non-empty: prog_ctr <= top entry; depth decrements.
  - ret_en, stack empty: stk_unf <= 1; prog_ctr <= prog_ctr+1.
  - call_en, stack not full: push prog_ctr+1 (mod 2^D); prog_ctr <= target; depth increments.
  - call_en, stack full: stk_ovf <= 1; push is dropped; jump to target still taken.
  - absjump_en: prog_ctr <= target.
  - reljump_en: prog_ctr <= prog_ctr + sign_extend(offset), mod 2^D. Wraps in both directions; no flag.
  - otherwise: prog_ctr <= prog_ctr + 1. The value 2^D-1 wraps to 0.
- Latency and flags:
  - All updates are registered; one-cycle latency from control input to prog_ctr.
  - stk_ovf and stk_unf are sticky and clear only on reset.
- Simultaneous events:
  - Lower-priority controls asserted in the same cycle are ignored; no partial effects.
  - halt_req together with a jump: the jump is taken, then HALT is entered.
- Stack:
  - LIFO, implemented as a register array with a depth pointer.
  - The top entry is always index depth-1.

Optional Feature:
- Macro: PC_RETSTACK_EN.
- Defined:
  - The return stack, call_en/ret_en handling, stk_depth, stk_ovf and stk_unf behave as above.
- Undefined:
  - No stack storage is built.
  - call_en acts as absjump_en (jump to target, nothing pushed).
  - ret_en acts as a plain increment.
  - stk_depth, stk_ovf and stk_unf are tied to 0.
  - All other behaviour is identical.

Test Plan:
- Reset and increment, D=10, RESET_VEC=0x010: hold reset_n=0 two cycles, then release with no controls -> prog_ctr 0x010, 0x011, 0x012; halted=0; flags 0.
- Wrap and relative branch: from prog_ctr=0x3FE, increment -> 0x3FF, then 0x000. From prog_ctr=0x005, reljump offset=0xFA (-6) -> 0x3FF. From 0x100, offset=0x7F -> 0x17F.
- Call/return nesting: at 0x020, call target=0x200 -> PC 0x200, depth 1. At 0x200, call target=0x300 -> PC 0x300, depth 2. Ret -> 0x201. Ret -> 0x021, depth 0; flags remain 0.
- Stack errors, DEPTH=4: five consecutive calls -> fifth jump taken, depth stays 4, stk_ovf=1. Then five rets -> fifth ret gives PC+1 and stk_unf=1; both flags remain 1 until reset.
- Priority/stall: ret_en+call_en+absjump_en asserted together -> only the pop occurs. stall=1 with call_en -> PC, depth and flags unchanged.
- Halt: halt_req with absjump target=0x0AA -> PC=0x0AA, halted=1. Three cycles of increment/jump requests -> PC holds 0x0AA. resume -> halted=0; next cycle PC=0x0AB. Reset while halted -> RESET_VEC, halted=0.
